// File: rtl/stage1_fetch_decode.sv
// stage1_fetch_decode
// Front pipeline stage: owns the PC, fetches from a synchronous-read
// instruction memory, decodes the returned word, reads the register file
// and registers {opcode, memAddr, regIndex, regDataIn} for the memory/IO stage.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   imemAddr / imemData   instruction word address out, instruction in (1-cycle read latency)
//   sr1Index / sr1Data    register port 1 (base register, inst[19:16])
//   sr2Index / sr2Data    register port 2 (data register, inst[23:20])
//   stall                 downstream cannot accept: hold all state
//   redirect, redirectPc  flush and restart fetch at redirectPc (word aligned)
//   opcode, memAddr, regIndex, regDataIn, valid   registered stage outputs
//   halted                stage is parked after a HALT instruction
//   dbg_state             current FSM state, for observation only
//
// Handshake: an output is consumed on every rising edge where valid=1 and
// stall=0; while stall=1 the outputs and valid are held unchanged.
module stage1_fetch_decode #(
    parameter logic [31:0] START_PC            = 32'h0000_0040,
    parameter int          IMEM_ADDR_BIT_WIDTH = 30,
    parameter int          DMEM_ADDR_BIT_WIDTH = 30,
    parameter int          DMEM_DATA_BIT_WIDTH = 32,
    parameter int          REG_INDEX_BIT_WIDTH = 4,
    parameter logic [7:0]  OP_HALT             = 8'hFF
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [IMEM_ADDR_BIT_WIDTH-1:0] imemAddr,
    input  logic [DMEM_DATA_BIT_WIDTH-1:0] imemData,
    output logic [REG_INDEX_BIT_WIDTH-1:0] sr1Index,
    input  logic [DMEM_DATA_BIT_WIDTH-1:0] sr1Data,
    output logic [REG_INDEX_BIT_WIDTH-1:0] sr2Index,
    input  logic [DMEM_DATA_BIT_WIDTH-1:0] sr2Data,
    input  logic                           stall,
    input  logic                           redirect,
    input  logic [DMEM_DATA_BIT_WIDTH-1:0] redirectPc,
    output logic [7:0]                     opcode,
    output logic [DMEM_ADDR_BIT_WIDTH-1:0] memAddr,
    output logic [REG_INDEX_BIT_WIDTH-1:0] regIndex,
    output logic [DMEM_DATA_BIT_WIDTH-1:0] regDataIn,
    output logic                           valid,
    output logic                           halted,
    output logic [1:0]                     dbg_state
);

    localparam int DW = DMEM_DATA_BIT_WIDTH;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [DW-1:0]                  fetch_pc_q, fetch_pc_d;
    logic [DW-1:0]                  decode_pc_q, decode_pc_d;
    logic                           decode_valid_q, decode_valid_d;
    logic [7:0]                     opcode_q, opcode_d;
    logic [DMEM_ADDR_BIT_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [REG_INDEX_BIT_WIDTH-1:0] reg_index_q, reg_index_d;
    logic [DW-1:0]                  reg_data_in_q, reg_data_in_d;
    logic                           valid_q, valid_d;

    // Decode of the instruction currently returned by the memory
    logic [7:0]    dec_opcode;
    logic [DW-1:0] dec_imm;
    logic [DW-1:0] dec_ea;

    assign dec_opcode = imemData[31:24];
    assign dec_imm    = {{(DW-16){imemData[15]}}, imemData[15:0]};
    assign dec_ea     = sr1Data + dec_imm;
    assign sr1Index   = imemData[19:16];
    assign sr2Index   = imemData[23:20];

    // While stalled with a live instruction in decode, re-request its address
    // so the synchronous memory keeps returning the same word.
    assign imemAddr = (stall && decode_valid_q) ? decode_pc_q[DW-1 -: IMEM_ADDR_BIT_WIDTH]
                                                : fetch_pc_q[DW-1 -: IMEM_ADDR_BIT_WIDTH];

    assign opcode    = opcode_q;
    assign memAddr   = mem_addr_q;
    assign regIndex  = reg_index_q;
    assign regDataIn = reg_data_in_q;
    assign valid     = valid_q;
    assign halted    = (state_q == S_HALTED);
    assign dbg_state = state_q;

    // Byte-offset bits that never influence a word address
    logic unused_low_bits;
    assign unused_low_bits = ^{dec_ea[1:0], redirectPc[1:0], decode_pc_q[1:0]};

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        decode_pc_d    = decode_pc_q;
        decode_valid_d = decode_valid_q;
        opcode_d       = opcode_q;
        mem_addr_d     = mem_addr_q;
        reg_index_d    = reg_index_q;
        reg_data_in_d  = reg_data_in_q;
        valid_d        = valid_q;

        if (redirect) begin
            fetch_pc_d     = {redirectPc[DW-1:2], 2'b00};
            decode_valid_d = 1'b0;
            valid_d        = 1'b0;
            state_d        = S_FILL;
        end else if (!stall) begin
            case (state_q)
                S_FILL: begin
                    decode_pc_d    = fetch_pc_q;
                    fetch_pc_d     = fetch_pc_q + DW'(4);
                    decode_valid_d = 1'b1;
                    state_d        = S_RUN;
                end
                S_RUN: begin
                    opcode_d      = dec_opcode;
                    mem_addr_d    = dec_ea[DW-1 -: DMEM_ADDR_BIT_WIDTH];
                    reg_index_d   = imemData[23:20];
                    reg_data_in_d = sr2Data;
                    valid_d       = decode_valid_q;
                    decode_pc_d   = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + DW'(4);
                    // The HALT itself is still presented once with valid=1
                    if (decode_valid_q && (dec_opcode == OP_HALT)) begin
                        state_d        = S_HALTED;
                        decode_valid_d = 1'b0;
                    end
                end
                S_HALTED: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_FILL;
            fetch_pc_q     <= START_PC;
            decode_pc_q    <= '0;
            decode_valid_q <= 1'b0;
            opcode_q       <= '0;
            mem_addr_q     <= '0;
            reg_index_q    <= '0;
            reg_data_in_q  <= '0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            decode_pc_q    <= decode_pc_d;
            decode_valid_q <= decode_valid_d;
            opcode_q       <= opcode_d;
            mem_addr_q     <= mem_addr_d;
            reg_index_q    <= reg_index_d;
            reg_data_in_q  <= reg_data_in_d;
            valid_q        <= valid_d;
        end
    end

endmodule

// File: tb/tb_stage1_fetch_decode.sv
module tb_stage1_fetch_decode;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        reset;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic [3:0]  sr1_index, sr2_index;
    logic [31:0] sr1_data, sr2_data;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [7:0]  opcode;
    logic [29:0] mem_addr;
    logic [3:0]  reg_index;
    logic [31:0] reg_data_in;
    logic        valid, halted;
    logic [1:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stage1_fetch_decode dut (
        .clk        (clk),
        .reset      (reset),
        .imemAddr   (imem_addr),
        .imemData   (imem_data),
        .sr1Index   (sr1_index),
        .sr1Data    (sr1_data),
        .sr2Index   (sr2_index),
        .sr2Data    (sr2_data),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirect_pc),
        .opcode     (opcode),
        .memAddr    (mem_addr),
        .regIndex   (reg_index),
        .regDataIn  (reg_data_in),
        .valid      (valid),
        .halted     (halted),
        .dbg_state  (dbg_state)
    );

    // Synchronous-read instruction memory and combinational register file
    logic [31:0] imem [0:1023];
    logic [31:0] rf   [0:15];

    always @(posedge clk) imem_data <= imem[imem_addr[9:0]];
    assign sr1_data = rf[sr1_index];
    assign sr2_data = rf[sr2_index];

    // ---------------- scoreboard ----------------
    logic [73:0] exp_q[$];
    logic [73:0] got, exp_v;
    int          n_vec, n_err;

    assign got = {opcode, mem_addr, reg_index, reg_data_in};

    function automatic logic [73:0] model(input logic [31:0] inst);
        logic [31:0] ea;
        ea = rf[inst[19:16]] + {{16{inst[15]}}, inst[15:0]};
        return {inst[31:24], ea[31:2], inst[23:20], rf[inst[23:20]]};
    endfunction

    task automatic push_range(input int base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(model(imem[(base + k) % 1024]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        n_vec++; if (got !== 74'd0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", got); end
        n_vec++; if (imem_addr !== 30'h10) begin n_err++; $display("FAIL reset_imem_addr got=%h exp=10", imem_addr); end
    endtask

    task automatic test_basic();
        push_range(32'h10, 6);
        reset = 1'b1;
        #1;
        n_vec++; if (imem_addr !== 30'h10) begin n_err++; $display("FAIL basic_addr_c0 got=%h exp=10", imem_addr); end
        tick();
        n_vec++; if (imem_addr !== 30'h11) begin n_err++; $display("FAIL basic_addr_c1 got=%h exp=11", imem_addr); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_c1 got=%0b exp=0", valid); end
        tick();
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_c2 got=%0b exp=1", valid); end
        n_vec++; if (opcode !== 8'h01) begin n_err++; $display("FAIL basic_opcode got=%h exp=01", opcode); end
        n_vec++; if (reg_index !== 4'd2) begin n_err++; $display("FAIL basic_reg_index got=%h exp=2", reg_index); end
        n_vec++; if (mem_addr !== 30'h41) begin n_err++; $display("FAIL basic_mem_addr got=%h exp=41", mem_addr); end
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL basic_out0 got=%h exp=%h", got, exp_v); end
        for (int i = 1; i < 6; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_vec++; if (got !== exp_v || valid !== 1'b1) begin
                n_err++; $display("FAIL basic_stream[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, exp_v);
            end
        end
    endtask

    task automatic test_stall();
        logic [73:0] snap;
        logic [29:0] addr_snap;
        push_range(32'h16, 3);
        snap  = got;
        stall = 1'b1;
        #1;
        addr_snap = imem_addr;
        n_vec++; if (addr_snap !== 30'h16) begin n_err++; $display("FAIL stall_addr got=%h exp=16", addr_snap); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (got !== snap || valid !== 1'b1 || imem_addr !== addr_snap) begin
                n_err++; $display("FAIL stall_hold[%0d] got=%h v=%0b a=%h exp=%h v=1 a=%h", i, got, valid, imem_addr, snap, addr_snap);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_vec++; if (got !== exp_v || valid !== 1'b1) begin
                n_err++; $display("FAIL stall_resume[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, exp_v);
            end
        end
    endtask

    task automatic test_sign_ext();
        push_range(32'h40, 2);
        do_redirect(32'h100);
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL sext_valid got=%0b exp=0", valid); end
        tick();
        tick();
        n_vec++; if (mem_addr !== 30'h3FFFFFFF) begin n_err++; $display("FAIL sext_neg got=%h exp=3fffffff", mem_addr); end
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL sext_out0 got=%h exp=%h", got, exp_v); end
        tick();
        n_vec++; if (mem_addr !== 30'h0) begin n_err++; $display("FAIL sext_wrap got=%h exp=0", mem_addr); end
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v) begin n_err++; $display("FAIL sext_out1 got=%h exp=%h", got, exp_v); end
    endtask

    task automatic test_redirect();
        push_range(32'h80, 2);
        stall = 1'b1;
        do_redirect(32'h203);
        stall = 1'b0;
        #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got=%0b exp=0", valid); end
        n_vec++; if (imem_addr !== 30'h80) begin n_err++; $display("FAIL redir_fill_addr got=%h exp=80", imem_addr); end
        tick();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_e1 got=%0b exp=0", valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_vec++; if (got !== exp_v || valid !== 1'b1) begin
                n_err++; $display("FAIL redir_out[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, exp_v);
            end
        end
    endtask

    task automatic test_pc_wrap();
        push_range(32'h3FE, 3);
        do_redirect(32'hFFFF_FFF8);
        n_vec++; if (imem_addr !== 30'h3FFFFFFE) begin n_err++; $display("FAIL wrap_addr0 got=%h exp=3ffffffe", imem_addr); end
        tick();
        n_vec++; if (imem_addr !== 30'h3FFFFFFF) begin n_err++; $display("FAIL wrap_addr1 got=%h exp=3fffffff", imem_addr); end
        tick();
        n_vec++; if (imem_addr !== 30'h0) begin n_err++; $display("FAIL wrap_addr2 got=%h exp=0", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            exp_v = exp_q.pop_front();
            n_vec++; if (got !== exp_v || valid !== 1'b1) begin
                n_err++; $display("FAIL wrap_out[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, exp_v);
            end
        end
    endtask

    task automatic test_halt();
        logic [73:0] halt_out;
        push_range(32'hC0, 3);
        do_redirect(32'h300);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            n_vec++; if (got !== exp_v || valid !== 1'b1) begin
                n_err++; $display("FAIL halt_out[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, exp_v);
            end
        end
        n_vec++; if (opcode !== 8'hFF) begin n_err++; $display("FAIL halt_opcode got=%h exp=ff", opcode); end
        halt_out = model(imem[32'hC2]);
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++; if (valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 30'hC4 || got !== halt_out) begin
                n_err++; $display("FAIL halt_park[%0d] v=%0b h=%0b a=%h out=%h exp v=0 h=1 a=c4 out=%h", i, valid, halted, imem_addr, got, halt_out);
            end
        end
        push_range(32'h10, 1);
        do_redirect(32'h40);
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_release got=%0b exp=0", halted); end
        tick();
        tick();
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v || valid !== 1'b1) begin
            n_err++; $display("FAIL halt_restart got=%h v=%0b exp=%h v=1", got, valid, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [73:0] prev;
        push_range(32'h100, 45);
        do_redirect(32'h400);
        tick();
        tick();
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v || valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_first got=%h v=%0b exp=%h v=1", got, valid, exp_v);
        end
        prev = got;
        for (int i = 0; i < 40; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            tick();
            if (stall) begin
                n_vec++; if (got !== prev || valid !== 1'b1) begin
                    n_err++; $display("FAIL b2b_hold[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, prev);
                end
            end else if (exp_q.size() == 0) begin
                n_vec++; n_err++; $display("FAIL b2b_underrun[%0d] got=%h exp=none", i, got);
            end else begin
                exp_v = exp_q.pop_front();
                n_vec++; if (got !== exp_v || valid !== 1'b1) begin
                    n_err++; $display("FAIL b2b_out[%0d] got=%h v=%0b exp=%h v=1", i, got, valid, exp_v);
                end
            end
            prev = got;
        end
        stall = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid got=%0b exp=1", valid); end
        #1;
        reset = 1'b0;
        #1;
        n_vec++; if (valid !== 1'b0 || halted !== 1'b0 || got !== 74'd0) begin
            n_err++; $display("FAIL areset_clear v=%0b h=%0b out=%h exp v=0 h=0 out=0", valid, halted, got);
        end
        n_vec++; if (imem_addr !== 30'h10) begin n_err++; $display("FAIL areset_addr got=%h exp=10", imem_addr); end
        tick();
        push_range(32'h10, 1);
        reset = 1'b1;
        #1;
        n_vec++; if (imem_addr !== 30'h10) begin n_err++; $display("FAIL areset_restart_addr got=%h exp=10", imem_addr); end
        tick();
        tick();
        exp_v = exp_q.pop_front();
        n_vec++; if (got !== exp_v || valid !== 1'b1) begin
            n_err++; $display("FAIL areset_restart got=%h v=%0b exp=%h v=1", got, valid, exp_v);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        logic [31:0] w;
        n_vec = 0;
        n_err = 0;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            if (w[31:24] == 8'hFF) w[31:24] = 8'h10;
            imem[i] = w;
        end
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        rf[1] = 32'h0000_0100;
        rf[4] = 32'h0000_0000;
        rf[5] = 32'h0000_8000;
        imem[32'h10] = 32'h0121_0004;
        imem[32'h11] = 32'h0230_0008;
        imem[32'h40] = 32'h0324_FFFC;
        imem[32'h41] = 32'h0435_8000;
        imem[32'hC2] = 32'hFF00_0000;

        test_reset();
        test_basic();
        test_stall();
        test_sign_ext();
        test_redirect();
        test_pc_wrap();
        test_halt();
        test_back_to_back();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
